dram_burst_datapath: RTL and testbench
======================================

// Module: dram_burst_datapath
// PURPOSE
//  Parametrised DRAM data-path engine: serialises one write burst onto a split DQ/DQS/DM bus and
//  deserialises one read burst from it, with critical-beat-first column ordering and wrap-around.
//  Sits between the DRAM command scheduler (burst-wide words) and the pad/PHY layer (per-beat pins).
//  Adds configurable bus width, burst length, write preamble, byte masking and a read timeout.
// PARAMETERS
//  DQ_W        8    bits per beat on DQ; multiple of 8
//  BL          8    beats per burst; power of 2, >=2
//  WPRE        1    write-preamble cycles (DQS driven low before first beat); >=1
//  RD_TIMEOUT  16   max consecutive cycles without a read beat before abort; >=2
// PORTS
//  CLK          in   1              system clock
//  nRST         in   1              asynchronous reset, active low
//  wr_req       in   1              start write burst (sampled only in IDLE)
//  rd_req       in   1              start read burst (sampled only in IDLE)
//  col_choice   in   $clog2(BL)     starting beat slot, latched with request
//  wr_data      in   BL*DQ_W        burst word; slot k = wr_data[k*DQ_W +: DQ_W]
//  wr_mask      in   BL*DQ_W/8      1 = mask byte; slot k bits [k*DQ_W/8 +: DQ_W/8]
//  dq_in        in   DQ_W           read beat from PHY
//  dq_in_valid  in   1              dq_in holds a strobe-captured beat this cycle
//  busy         out  1              engine not in IDLE
//  dq_out       out  DQ_W           write beat to PHY
//  dq_oe        out  1              DQ drive enable
//  dqs_t/dqs_c  out  1/1            write strobe pair, dqs_c = ~dqs_t whenever dqs_oe=1
//  dqs_oe       out  1              DQS drive enable
//  dm_n         out  DQ_W/8         data mask, active low (0 = byte masked)
//  edge_flag    out  1              toggles once per transferred beat (either direction)
//  rd_data      out  BL*DQ_W        assembled read burst, slot layout as wr_data
//  rd_valid     out  1              one-cycle pulse: rd_data complete
//  wr_done      out  1              one-cycle pulse: write burst + postamble finished
//  rd_err       out  1              one-cycle pulse: read aborted on timeout
// BEHAVIOUR
//  Reset (async, nRST=0): state IDLE; all outputs 0 except dm_n='1, dqs_c=0; counters and rd_data 0.
//  States: IDLE, WR_PRE, WR_BURST, WR_POST, RD_BURST.
//  IDLE: wr_req -> WR_PRE (latch wr_data, wr_mask, col_choice); else rd_req -> RD_BURST.
//   wr_req and rd_req together: write wins, read dropped. Requests outside IDLE ignored.
//  WR_PRE: WPRE cycles, dqs_oe=1, dqs_t=0, dq_oe=0.
//  WR_BURST: BL cycles; beat i drives slot s=(col+i) mod BL (wrap with $clog2(BL)-bit add, carry dropped);
//   dq_oe=1, dqs_oe=1, dqs_t=1 on even i, 0 on odd i; dm_n = ~mask[s]; edge_flag toggles each beat.
//   wr_req at edge N -> first beat visible after edge N+1+WPRE.
//  WR_POST: 1 cycle dqs_oe=1, dqs_t=0, dq_oe=0, dm_n='1; wr_done=1 this cycle; next IDLE.
//  RD_BURST: all drive enables 0. Each cycle with dq_in_valid=1 stores dq_in in slot (col+n) mod BL,
//   n = beats received so far; edge_flag toggles; idle counter clears. Cycles without valid increment
//   idle counter. On BL-th beat: rd_valid=1 next cycle with full rd_data, -> IDLE.
//   Idle counter reaching RD_TIMEOUT -> rd_err=1 for one cycle, -> IDLE; partial beats discarded
//   (rd_data keeps previous completed burst). Beat and timeout in same cycle: beat wins.
//  dq_in_valid outside RD_BURST ignored. rd_data stable except at rd_valid update.
//  Reset mid-burst: enables drop immediately, no done/valid/err pulse, partial data lost.
// STRUCTURE
//  dram_pkg: burst_state_t enum, default DQ_W/BL constants, beat index type.
//  Sub-module dram_rd_assembler: slot-indexed BL x DQ_W capture registers + beat counter
//   (in: beat, valid, start slot, clear; out: word, complete). FSM, strobe and write mux in top.
// TESTING
//  Write, DQ_W=8 BL=8 col=0 data 64'h0011223344556677 mask 0 -> beats 77,66,..,00; dqs_t 1,0,..; wr_done at cycle 11.
//  Write col=5 same data, mask slot 6 byte set -> beats 22,11,00,77,..,33; dm_n=0 only on 2nd beat.
//  Read col=3, 8 valid beats A0..A7 with 2-cycle gaps -> rd_data slots 3..7,0..2 = A0..A7; one rd_valid.
//  Read with 3 beats then silence -> rd_err exactly RD_TIMEOUT cycles after last beat; rd_data unchanged.
//  wr_req and rd_req same cycle -> write burst only; busy high; later rd_req during busy ignored.
//  nRST low mid WR_BURST -> dq_oe/dqs_oe 0 same cycle, no wr_done; fresh write after reset correct.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and default geometry for the DRAM burst data-path engine.
package dram_pkg;

  localparam int DQ_W_DEF = 8;
  localparam int BL_DEF   = 8;

  typedef logic [$clog2(BL_DEF)-1:0] beat_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PRE,
    ST_WR_BURST,
    ST_WR_POST,
    ST_RD_BURST
  } burst_state_t;

endpackage

// File: rtl/dram_rd_assembler.sv
// Read-burst capture: stores each incoming beat in its wrapped slot and presents
// the full word (including the beat arriving this cycle) when the last beat lands.
module dram_rd_assembler #(
  parameter int DQ_W = 8,
  parameter int BL   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DQ_W-1:0]         beat_i,
  input  logic                    valid_i,
  input  logic [$clog2(BL)-1:0]   start_slot_i,
  input  logic                    clear_i,
  output logic [BL*DQ_W-1:0]      word_o,
  output logic                    complete_o
);

  localparam int IW = $clog2(BL);

  logic [DQ_W-1:0] slots_q [BL];
  logic [IW-1:0]   cnt_q;
  logic [IW-1:0]   wr_slot;

  // Slot wraps naturally through the IW-bit add; the carry is dropped.
  assign wr_slot    = start_slot_i + cnt_q;
  assign complete_o = valid_i && (cnt_q == IW'(BL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (valid_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: capture slots carry no reset; they are only published after all BL
  // slots of the current burst have been written since the last clear.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      slots_q[wr_slot] <= beat_i;
    end
  end

  always_comb begin
    word_o = '0;
    for (int k = 0; k < BL; k++) begin
      word_o[k*DQ_W +: DQ_W] = (valid_i && (wr_slot == IW'(k))) ? beat_i : slots_q[k];
    end
  end

endmodule

// File: rtl/dram_burst_datapath.sv
// DRAM burst data-path engine: serialises a write burst onto DQ/DQS/DM and
// deserialises a read burst, with critical-beat-first wrap ordering.
module dram_burst_datapath
  import dram_pkg::*;
#(
  parameter int DQ_W       = DQ_W_DEF,
  parameter int BL         = BL_DEF,
  parameter int WPRE       = 1,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     wr_req,
  input  logic                     rd_req,
  input  logic [$clog2(BL)-1:0]    col_choice,
  input  logic [BL*DQ_W-1:0]       wr_data,
  input  logic [BL*DQ_W/8-1:0]     wr_mask,
  input  logic [DQ_W-1:0]          dq_in,
  input  logic                     dq_in_valid,
  output logic                     busy,
  output logic [DQ_W-1:0]          dq_out,
  output logic                     dq_oe,
  output logic                     dqs_t,
  output logic                     dqs_c,
  output logic                     dqs_oe,
  output logic [DQ_W/8-1:0]        dm_n,
  output logic                     edge_flag,
  output logic [BL*DQ_W-1:0]       rd_data,
  output logic                     rd_valid,
  output logic                     wr_done,
  output logic                     rd_err
);

  localparam int IW = $clog2(BL);
  localparam int MW = DQ_W / 8;
  localparam int CW = $clog2(((WPRE > BL) ? WPRE : BL) + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  burst_state_t        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic [IW-1:0]       col_q;
  logic [BL*DQ_W-1:0]  wdata_q;
  logic [BL*MW-1:0]    wmask_q;
  logic                busy_q;
  logic                latch_wr, latch_col, asm_clear;
  logic [IW-1:0]       slot;

  // Pad-facing outputs are registered: they show the state of the previous cycle.
  logic [DQ_W-1:0]     dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                dqs_t_q, dqs_t_d;
  logic                dqs_oe_q, dqs_oe_d;
  logic [MW-1:0]       dm_n_q, dm_n_d;
  logic                edge_q, edge_d;
  logic [BL*DQ_W-1:0]  rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_done_q, wr_done_d;
  logic                rd_err_q, rd_err_d;

  logic                asm_valid;
  logic [BL*DQ_W-1:0]  asm_word;
  logic                asm_complete;

  assign slot      = col_q + cnt_q[IW-1:0];
  assign asm_valid = dq_in_valid && (state_q == ST_RD_BURST);

  dram_rd_assembler #(
    .DQ_W (DQ_W),
    .BL   (BL)
  ) u_rd_assembler (
    .clk          (CLK),
    .rst_n        (nRST),
    .beat_i       (dq_in),
    .valid_i      (asm_valid),
    .start_slot_i (col_q),
    .clear_i      (asm_clear),
    .word_o       (asm_word),
    .complete_o   (asm_complete)
  );

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    latch_wr   = 1'b0;
    latch_col  = 1'b0;
    asm_clear  = 1'b0;
    dq_out_d   = '0;
    dq_oe_d    = 1'b0;
    dqs_t_d    = 1'b0;
    dqs_oe_d   = 1'b0;
    dm_n_d     = '1;
    edge_d     = edge_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    rd_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy_q covers the trailing cycle where the last outputs are still on the pins.
        if (!busy_q) begin
          if (wr_req) begin
            state_d   = ST_WR_PRE;
            cnt_d     = '0;
            latch_wr  = 1'b1;
            latch_col = 1'b1;
          end else if (rd_req) begin
            state_d   = ST_RD_BURST;
            idle_d    = '0;
            latch_col = 1'b1;
            asm_clear = 1'b1;
          end
        end
      end

      ST_WR_PRE: begin
        dqs_oe_d = 1'b1;
        if (cnt_q == CW'(WPRE - 1)) begin
          state_d = ST_WR_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WR_BURST: begin
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dqs_t_d  = ~cnt_q[0];
        dq_out_d = wdata_q[slot*DQ_W +: DQ_W];
        dm_n_d   = ~wmask_q[slot*MW +: MW];
        edge_d   = ~edge_q;
        if (cnt_q == CW'(BL - 1)) begin
          state_d = ST_WR_POST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WR_POST: begin
        dqs_oe_d  = 1'b1;
        wr_done_d = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_RD_BURST: begin
        // A beat in the same cycle as an expiring idle count takes priority.
        if (dq_in_valid) begin
          edge_d = ~edge_q;
          idle_d = '0;
          if (asm_complete) begin
            rd_data_d  = asm_word;
            rd_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (idle_q == TW'(RD_TIMEOUT - 1)) begin
          rd_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idle_q     <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      busy_q     <= 1'b0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      dqs_t_q    <= 1'b0;
      dqs_oe_q   <= 1'b0;
      dm_n_q     <= '1;
      edge_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      busy_q     <= (state_q != ST_IDLE);
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      dqs_t_q    <= dqs_t_d;
      dqs_oe_q   <= dqs_oe_d;
      dm_n_q     <= dm_n_d;
      edge_q     <= edge_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      rd_err_q   <= rd_err_d;
      if (latch_col) begin
        col_q <= col_choice;
      end
      if (latch_wr) begin
        wdata_q <= wr_data;
        wmask_q <= wr_mask;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE) || busy_q;
  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_t     = dqs_t_q;
  assign dqs_c     = dqs_oe_q & ~dqs_t_q;
  assign dqs_oe    = dqs_oe_q;
  assign dm_n      = dm_n_q;
  assign edge_flag = edge_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_done   = wr_done_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_dram_burst_datapath.sv
// Self-checking bench for dram_burst_datapath against a slot-ordering reference model.
module tb_dram_burst_datapath;
  import dram_pkg::*;

  localparam int DQ_W       = 8;
  localparam int BL         = 8;
  localparam int WPRE       = 1;
  localparam int RD_TIMEOUT = 16;
  localparam int MW         = DQ_W / 8;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic                  wr_req, rd_req;
  beat_idx_t             col_choice;
  logic [BL*DQ_W-1:0]    wr_data;
  logic [BL*MW-1:0]      wr_mask;
  logic [DQ_W-1:0]       dq_in;
  logic                  dq_in_valid;
  logic                  busy, dq_oe, dqs_t, dqs_c, dqs_oe, edge_flag;
  logic [DQ_W-1:0]       dq_out;
  logic [MW-1:0]         dm_n;
  logic [BL*DQ_W-1:0]    rd_data;
  logic                  rd_valid, wr_done, rd_err;

  int                    checks = 0;
  int                    errors = 0;
  logic                  exp_edge;
  logic [BL*DQ_W-1:0]    ref_rd;
  logic [DQ_W-1:0]       beat_vals [BL];

  dram_burst_datapath #(
    .DQ_W(DQ_W), .BL(BL), .WPRE(WPRE), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .CLK(CLK), .nRST(nRST), .wr_req(wr_req), .rd_req(rd_req),
    .col_choice(col_choice), .wr_data(wr_data), .wr_mask(wr_mask),
    .dq_in(dq_in), .dq_in_valid(dq_in_valid), .busy(busy), .dq_out(dq_out),
    .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c), .dqs_oe(dqs_oe), .dm_n(dm_n),
    .edge_flag(edge_flag), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_done(wr_done), .rd_err(rd_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic do_write(input logic [BL*DQ_W-1:0] data, input logic [BL*MW-1:0] mask,
                          input beat_idx_t col, input bit hold_rd);
    int s;
    logic [DQ_W-1:0] eb;
    logic [MW-1:0]   em;
    wr_data = data; wr_mask = mask; col_choice = col; wr_req = 1'b1; rd_req = hold_rd;
    @(negedge CLK);
    wr_req = 1'b0;
    wr_data = ~data; wr_mask = ~mask; col_choice = ~col;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_start: got %b want 1", busy); end
    for (int p = 0; p < WPRE; p++) begin
      @(negedge CLK);
      checks++;
      if ({dq_oe, dqs_oe, dqs_t, dqs_c, dm_n} !== {1'b0, 1'b1, 1'b0, 1'b1, {MW{1'b1}}}) begin
        errors++;
        $display("FAIL wr_preamble[%0d]: got oe=%b dqs_oe=%b t=%b c=%b dm_n=%h", p, dq_oe, dqs_oe, dqs_t, dqs_c, dm_n);
      end
    end
    for (int i = 0; i < BL; i++) begin
      @(negedge CLK);
      s = (int'(col) + i) % BL;
      eb = data[s*DQ_W +: DQ_W];
      em = ~mask[s*MW +: MW];
      exp_edge = ~exp_edge;
      checks++;
      if ({dq_oe, dqs_oe, dqs_t, dqs_c, dq_out, dm_n, edge_flag, busy, wr_done} !==
          {1'b1, 1'b1, 1'((i % 2) == 0), 1'((i % 2) != 0), eb, em, exp_edge, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL wr_beat[%0d]: got dq=%h dm_n=%h t=%b c=%b oe=%b/%b edge=%b done=%b want dq=%h dm_n=%h t=%b edge=%b",
                 i, dq_out, dm_n, dqs_t, dqs_c, dq_oe, dqs_oe, edge_flag, wr_done, eb, em, (i % 2) == 0, exp_edge);
      end
    end
    @(negedge CLK);
    checks++;
    if ({dq_oe, dqs_oe, dqs_t, dqs_c, dm_n, wr_done, busy} !== {1'b0, 1'b1, 1'b0, 1'b1, {MW{1'b1}}, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wr_postamble: got oe=%b dqs_oe=%b t=%b c=%b dm_n=%h done=%b busy=%b", dq_oe, dqs_oe, dqs_t, dqs_c, dm_n, wr_done, busy);
    end
    @(negedge CLK);
    checks++;
    if ({dq_oe, dqs_oe, wr_done, busy, edge_flag} !== {1'b0, 1'b0, 1'b0, 1'b0, exp_edge}) begin
      errors++;
      $display("FAIL wr_idle_after: got oe=%b dqs_oe=%b done=%b busy=%b edge=%b", dq_oe, dqs_oe, wr_done, busy, edge_flag);
    end
    rd_req = 1'b0;
    if (hold_rd) begin
      @(negedge CLK);
      checks++;
      if ({busy, rd_valid, rd_err} !== 3'b000) begin
        errors++;
        $display("FAIL rd_dropped: got busy=%b rd_valid=%b rd_err=%b want 000", busy, rd_valid, rd_err);
      end
    end
  endtask

  // Reads beat_vals[0..nbeats-1]; nbeats < BL leads to a timeout.
  task automatic do_read(input beat_idx_t col, input int nbeats, input int gmin, input int gmax);
    logic [BL*DQ_W-1:0] exp_word;
    int g;
    exp_word = ref_rd;
    col_choice = col; rd_req = 1'b1;
    @(negedge CLK);
    rd_req = 1'b0; col_choice = ~col;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_start: got %b want 1", busy); end
    for (int b = 0; b < nbeats; b++) begin
      g = $urandom_range(gmax, gmin);
      for (int j = 0; j < g; j++) begin
        dq_in = DQ_W'($urandom); dq_in_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if ({rd_valid, rd_err, dq_oe, dqs_oe} !== 4'b0000) begin
          errors++;
          $display("FAIL rd_gap: got rd_valid=%b rd_err=%b oe=%b dqs_oe=%b want 0000", rd_valid, rd_err, dq_oe, dqs_oe);
        end
      end
      dq_in = beat_vals[b]; dq_in_valid = 1'b1;
      @(negedge CLK);
      dq_in_valid = 1'b0;
      exp_word[((int'(col) + b) % BL)*DQ_W +: DQ_W] = beat_vals[b];
      exp_edge = ~exp_edge;
      if (b == BL - 1) ref_rd = exp_word;
      checks++;
      if ({edge_flag, rd_valid, rd_err, rd_data} !== {exp_edge, 1'(b == BL - 1), 1'b0, ref_rd}) begin
        errors++;
        $display("FAIL rd_beat[%0d]: got edge=%b valid=%b err=%b data=%h want edge=%b valid=%b data=%h",
                 b, edge_flag, rd_valid, rd_err, rd_data, exp_edge, b == BL - 1, ref_rd);
      end
    end
    if (nbeats < BL) begin
      for (int c = 1; c <= RD_TIMEOUT; c++) begin
        dq_in = DQ_W'($urandom);
        @(negedge CLK);
        checks++;
        if ({rd_err, rd_valid} !== {1'(c == RD_TIMEOUT), 1'b0}) begin
          errors++;
          $display("FAIL rd_timeout[%0d]: got err=%b valid=%b want err=%b", c, rd_err, rd_valid, c == RD_TIMEOUT);
        end
      end
      checks++;
      if (rd_data !== ref_rd) begin errors++; $display("FAIL rd_data_kept: got %h want %h", rd_data, ref_rd); end
    end
    @(negedge CLK);
    checks++;
    if ({busy, rd_valid, rd_err, rd_data} !== {3'b000, ref_rd}) begin
      errors++;
      $display("FAIL rd_end: got busy=%b valid=%b err=%b data=%h want data=%h", busy, rd_valid, rd_err, rd_data, ref_rd);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, dm_n, edge_flag, rd_data, rd_valid, wr_done, rd_err} !==
        {1'b0, {DQ_W{1'b0}}, 4'b0000, {MW{1'b1}}, 1'b0, {BL*DQ_W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b dq=%h oe=%b t=%b c=%b dqs_oe=%b dm_n=%h edge=%b rd_data=%h pulses=%b%b%b",
               busy, dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, dm_n, edge_flag, rd_data, rd_valid, wr_done, rd_err);
    end
  endtask

  task automatic test_write_basic();
    do_write(64'h0011223344556677, '0, beat_idx_t'(0), 1'b0);
  endtask

  task automatic test_write_wrap_mask();
    do_write(64'h0011223344556677, 8'b0100_0000, beat_idx_t'(5), 1'b0);
  endtask

  task automatic test_read_gaps();
    for (int i = 0; i < BL; i++) beat_vals[i] = DQ_W'(8'hA0 + i);
    do_read(beat_idx_t'(3), BL, 2, 2);
  endtask

  task automatic test_read_timeout();
    for (int i = 0; i < BL; i++) beat_vals[i] = DQ_W'($urandom);
    do_read(beat_idx_t'($urandom_range(BL - 1, 0)), 3, 0, 3);
  endtask

  task automatic test_write_read_collision();
    do_write({$urandom, $urandom}, BL*MW'($urandom), beat_idx_t'($urandom_range(BL - 1, 0)), 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    wr_data = {$urandom, $urandom}; wr_mask = '0; col_choice = beat_idx_t'(2); wr_req = 1'b1;
    @(negedge CLK);
    wr_req = 1'b0;
    repeat (WPRE + 3) @(negedge CLK);
    checks++;
    if ({dq_oe, dqs_oe} !== 2'b11) begin errors++; $display("FAIL mid_burst_active: got oe=%b dqs_oe=%b want 11", dq_oe, dqs_oe); end
    #2 nRST = 1'b0;
    #1;
    exp_edge = 1'b0;
    ref_rd = '0;
    checks++;
    if ({dq_oe, dqs_oe, dqs_t, dqs_c, busy, dm_n, edge_flag, dq_out, wr_done} !==
        {5'b00000, {MW{1'b1}}, 1'b0, {DQ_W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got oe=%b dqs_oe=%b t=%b c=%b busy=%b dm_n=%h edge=%b dq=%h done=%b",
               dq_oe, dqs_oe, dqs_t, dqs_c, busy, dm_n, edge_flag, dq_out, wr_done);
    end
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b1;
    repeat (BL + 2) begin
      @(negedge CLK);
      checks++;
      if ({wr_done, busy, dq_oe} !== 3'b000) begin
        errors++;
        $display("FAIL no_done_after_reset: got done=%b busy=%b oe=%b want 000", wr_done, busy, dq_oe);
      end
    end
    do_write({$urandom, $urandom}, BL*MW'($urandom), beat_idx_t'($urandom_range(BL - 1, 0)), 1'b0);
  endtask

  task automatic test_back_to_back();
    int nb;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_write({$urandom, $urandom}, BL*MW'($urandom), beat_idx_t'($urandom_range(BL - 1, 0)), 1'b0);
      end else begin
        for (int i = 0; i < BL; i++) beat_vals[i] = DQ_W'($urandom);
        nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(BL - 1, 0)) : BL;
        do_read(beat_idx_t'($urandom_range(BL - 1, 0)), nb, 0, 3);
      end
    end
  endtask

  initial begin
    nRST = 1'b0; wr_req = 1'b0; rd_req = 1'b0; col_choice = '0;
    wr_data = '0; wr_mask = '0; dq_in = '0; dq_in_valid = 1'b0;
    exp_edge = 1'b0; ref_rd = '0;
    repeat (2) @(negedge CLK);
    test_reset();
    #2 nRST = 1'b1;
    @(negedge CLK);
    test_write_basic();
    test_write_wrap_mask();
    test_read_gaps();
    test_read_timeout();
    test_write_read_collision();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
